i2s_tdm_trx: RTL and testbench

I2S_TDM_TRX -- requirements
Module: i2s_tdm_trx

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_frame_tracker.sv | 64 ++++++
 rtl/i2s_tdm_trx.sv | 105 ++++++++++
 tb/tb_i2s_tdm_trx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, tracker state type and sizing helpers for the I2S/TDM transceiver.
package i2s_pkg;

    localparam bit FS_LOW  = 1'b0;
    localparam bit FS_HIGH = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } trk_state_e;

    function automatic int unsigned frame_bits(input int unsigned channels,
                                               input int unsigned slot_size);
        return channels * slot_size;
    endfunction

    // Counter must hold 0..FRAME_BITS inclusive so it can saturate at FRAME_BITS.
    function automatic int unsigned cnt_width(input int unsigned fbits);
        return $clog2(fbits + 1);
    endfunction

endpackage

// File: rtl/i2s_frame_tracker.sv
// Frame-sync edge detection, bit-position counter, lock state and frame-length checking.
module i2s_frame_tracker
    import i2s_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 32,
    parameter bit          FS_POL     = FS_LOW,
    parameter int unsigned CW         = cnt_width(FRAME_BITS)
) (
    input  logic          bclk,
    input  logic          reset,
    input  logic          enable,
    input  logic          lrclk,
    output logic          locked,
    output logic          frame_err,
    output logic [CW-1:0] k,
    output logic          frame_start_c,
    output logic          frame_good_c
);

    trk_state_e state;
    logic       lrclk_q;

    assign locked = (state == LOCKED);

    // Only the transition into FS_POL starts a frame; the mid-frame edge is ignored.
    always_comb begin
        frame_start_c = (lrclk == FS_POL) && (lrclk_q != FS_POL);
        frame_good_c  = frame_start_c && enable && (state == LOCKED)
                        && (k == CW'(FRAME_BITS - 1));
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state     <= UNLOCKED;
            lrclk_q   <= FS_POL;
            k         <= '0;
            frame_err <= 1'b0;
        end else begin
            lrclk_q   <= lrclk;
            frame_err <= 1'b0;
            if (frame_start_c) begin
                k <= '0;
            end else if (k != CW'(FRAME_BITS)) begin
                k <= k + CW'(1);
            end
            case (state)
                UNLOCKED: begin
                    if (frame_start_c && enable) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (!enable) begin
                        state <= UNLOCKED;
                    end else if (frame_start_c && !frame_good_c) begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tdm_trx.sv
// I2S/TDM transceiver: MSB-first serialiser/deserialiser with one-bclk data delay,
// tx shadow latched at frame start, per-slot enables.
module i2s_tdm_trx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_SIZE = 16,
    parameter int unsigned SLOT_SIZE   = 16,
    parameter int unsigned CHANNELS    = 2,
    parameter bit          FS_POL      = FS_LOW
) (
    input  logic                            bclk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            lrclk,
    input  logic                            din,
    output logic                            dout,
    input  logic [CHANNELS-1:0]             slot_en,
    input  logic [CHANNELS*SAMPLE_SIZE-1:0] tx_data,
    output logic [CHANNELS*SAMPLE_SIZE-1:0] rx_data,
    output logic                            rx_valid,
    output logic                            frame_err,
    output logic                            locked
);

    localparam int unsigned FRAME_BITS = frame_bits(CHANNELS, SLOT_SIZE);
    localparam int unsigned CW         = cnt_width(FRAME_BITS);
    localparam int unsigned DW         = CHANNELS * SAMPLE_SIZE;

    logic [CW-1:0]         k;
    logic                  frame_start_c;
    logic                  frame_good_c;
    logic [FRAME_BITS-1:0] tx_sh;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] rx_next_c;
    logic [FRAME_BITS-1:0] tx_ser_c;
    logic [FRAME_BITS-1:0] en_mask_c;
    logic [DW-1:0]         rx_asm_c;
    logic                  tx_bit_c;

    i2s_frame_tracker #(
        .FRAME_BITS (FRAME_BITS),
        .FS_POL     (FS_POL),
        .CW         (CW)
    ) u_tracker (
        .bclk          (bclk),
        .reset         (reset),
        .enable        (enable),
        .lrclk         (lrclk),
        .locked        (locked),
        .frame_err     (frame_err),
        .k             (k),
        .frame_start_c (frame_start_c),
        .frame_good_c  (frame_good_c)
    );

    // Newest din lands in bit 0, so frame bit e sits at index FRAME_BITS-1-e.
    assign rx_next_c = FRAME_BITS'({rx_sr, din});

    // tx_ser_c / en_mask_c are indexed by frame bit e; padding stays 0.
    always_comb begin
        tx_ser_c  = '0;
        en_mask_c = '0;
        rx_asm_c  = '0;
        for (int unsigned s = 0; s < CHANNELS; s++) begin
            for (int unsigned b = 0; b < SLOT_SIZE; b++) begin
                en_mask_c[s*SLOT_SIZE + b] = slot_en[s];
                if (b < SAMPLE_SIZE) begin
                    tx_ser_c[s*SLOT_SIZE + b] = tx_data[s*SAMPLE_SIZE + SAMPLE_SIZE - 1 - b];
                    rx_asm_c[s*SAMPLE_SIZE + SAMPLE_SIZE - 1 - b] =
                        slot_en[s] & rx_next_c[FRAME_BITS - 1 - (s*SLOT_SIZE + b)];
                end
            end
        end
    end

    assign tx_bit_c = |(tx_sh & en_mask_c & (FRAME_BITS'(1) << k));

    always_ff @(posedge bclk) begin
        if (reset) begin
            tx_sh    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sr    <= rx_next_c;
            rx_valid <= frame_good_c;
            if (frame_start_c) begin
                tx_sh <= tx_ser_c;
            end
            if (frame_good_c) begin
                rx_data <= rx_asm_c;
            end
        end
    end

    // Launch on the falling edge so the far end samples mid-bit on the next rising edge.
    always_ff @(negedge bclk) begin
        if (reset) begin
            dout <= 1'b0;
        end else begin
            dout <= locked && enable && (k < CW'(FRAME_BITS)) && tx_bit_c;
        end
    end

endmodule

// File: tb/tb_i2s_tdm_trx.sv
// Directed bench: default stereo loopback, 4-slot TDM with a disabled slot,
// 64-bit frames for length errors and saturation, reset and enable behaviour.
module tb_i2s_tdm_trx;

    localparam logic FS = 1'b0;

    logic bclk;
    logic reset;
    logic lrclk;

    logic         ena, douta, rva, fea, lka;
    logic [1:0]   sea;
    logic [31:0]  txa, rxa;
    logic         enb, doutb, rvb, feb, lkb;
    logic [3:0]   seb;
    logic [95:0]  txb, rxb;
    logic         enc, doutc, rvc, fec, lkc;
    logic [1:0]   sec;
    logic [63:0]  txc, rxc;

    logic [31:0]  wa;
    logic [127:0] wb;
    logic [63:0]  wc;
    logic         extc;
    int nrva, nfea, nrvb, nfeb, nrvc, nfec;
    int total, bad;

    i2s_tdm_trx u_a (
        .bclk(bclk), .reset(reset), .enable(ena), .lrclk(lrclk), .din(douta),
        .dout(douta), .slot_en(sea), .tx_data(txa), .rx_data(rxa),
        .rx_valid(rva), .frame_err(fea), .locked(lka)
    );

    i2s_tdm_trx #(.SAMPLE_SIZE(24), .SLOT_SIZE(32), .CHANNELS(4)) u_b (
        .bclk(bclk), .reset(reset), .enable(enb), .lrclk(lrclk), .din(doutb),
        .dout(doutb), .slot_en(seb), .tx_data(txb), .rx_data(rxb),
        .rx_valid(rvb), .frame_err(feb), .locked(lkb)
    );

    i2s_tdm_trx #(.SAMPLE_SIZE(32), .SLOT_SIZE(32), .CHANNELS(2)) u_c (
        .bclk(bclk), .reset(reset), .enable(enc), .lrclk(lrclk), .din(doutc),
        .dout(doutc), .slot_en(sec), .tx_data(txc), .rx_data(rxc),
        .rx_valid(rvc), .frame_err(fec), .locked(lkc)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa = '0; wb = '0; wc = '0; extc = 1'b0;
        nrva = 0; nfea = 0; nrvb = 0; nfeb = 0; nrvc = 0; nfec = 0;
    endtask

    // lo bclks at FS level then hi bclks at the other level; dout captured as frame bit i.
    task automatic run_frame(input int lo, input int hi);
        for (int i = 0; i < lo + hi; i++) begin
            lrclk = (i < lo) ? FS : ~FS;
            @(posedge bclk); #1;
            if (rva === 1'b1) nrva++;
            if (fea === 1'b1) nfea++;
            if (rvb === 1'b1) nrvb++;
            if (feb === 1'b1) nfeb++;
            if (rvc === 1'b1) nrvc++;
            if (fec === 1'b1) nfec++;
            @(negedge bclk); #1;
            if (i < 32)  wa = {wa[30:0], douta};
            if (i < 128) wb = {wb[126:0], doutb};
            if (i < 64) wc = {wc[62:0], doutc};
            else        extc = extc | doutc;
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; lrclk = ~FS;
        ena = 1'b1; sea = 2'b11; txa = {16'h1234, 16'hA5C3};
        enb = 1'b0; seb = 4'b1011; txb = {24'h5A5A5A, 24'hFFFFFF, 24'h123456, 24'hABCDEF};
        enc = 1'b0; sec = 2'b11;   txc = {32'h0F1E2D3C, 32'hDEADBEEF};
        clr();

        // Reset state
        run_frame(0, 3);
        chk("rst_locked", lka, 0);
        chk("rst_rx_valid", rva, 0);
        chk("rst_frame_err", fea, 0);
        chk("rst_rx_data", rxa, 0);
        chk("rst_dout", douta, 0);
        reset = 1'b0;
        run_frame(0, 2);

        // Default stereo: lock frame, then two good frames
        clr(); run_frame(16, 16);
        chk("a_lock", lka, 1);
        chk("a_lock_no_rv", nrva, 0);
        chk("a_dout_f1", wa, 32'hA5C31234);
        clr(); run_frame(16, 16);
        chk("a_rv_f2", nrva, 1);
        chk("a_rx_f2", rxa, 32'h1234A5C3);
        chk("a_fe_f2", nfea, 0);
        clr(); run_frame(16, 16);
        chk("a_rv_f3", nrva, 1);
        chk("a_rx_f3", rxa, 32'h1234A5C3);

        // tx_data change mid-frame must not reach dout
        clr(); run_frame(16, 0);
        txa = 32'hFFFF_FFFF;
        run_frame(0, 16);
        chk("a_tx_shadow", wa, 32'hA5C31234);
        clr(); run_frame(8, 0);
        chk("a_rv_split", nrva, 1);
        chk("a_rx_split", rxa, 32'h1234A5C3);
        chk("a_dout_new", douta, 1);
        ena = 1'b0;
        @(posedge bclk); #1;
        chk("a_unlock", lka, 0);
        @(negedge bclk); #1;
        chk("a_dout_disabled", douta, 0);

        // 4-slot TDM, 24-bit samples in 32-bit slots, slot 2 disabled
        enb = 1'b1;
        run_frame(0, 2);
        clr(); run_frame(64, 64);
        chk("b_lock", lkb, 1);
        chk("b_lock_no_rv", nrvb, 0);
        chk("b_dout", wb, 128'hABCDEF00_12345600_00000000_5A5A5A00);
        clr(); run_frame(64, 64);
        chk("b_rv", nrvb, 1);
        chk("b_rx", rxb, {24'h5A5A5A, 24'h000000, 24'h123456, 24'hABCDEF});
        chk("b_fe", nfeb, 0);
        enb = 1'b0;

        // 64-bit frames: short frame and saturated frame
        enc = 1'b1;
        clr(); run_frame(32, 32);
        chk("c_lock", lkc, 1);
        chk("c_dout_f1", wc, 64'hDEADBEEF_0F1E2D3C);
        clr(); run_frame(30, 30);
        chk("c_rv_before_short", nrvc, 1);
        chk("c_fe_before_short", nfec, 0);
        clr(); run_frame(32, 32);
        chk("c_fe_short", nfec, 1);
        chk("c_rv_short", nrvc, 0);
        chk("c_locked_after_err", lkc, 1);
        clr(); run_frame(100, 100);
        chk("c_rv_after_short", nrvc, 1);
        chk("c_rx_after_short", rxc, 64'h0F1E2D3C_DEADBEEF);
        chk("c_fe_after_short", nfec, 0);
        chk("c_dout_long", wc, 64'hDEADBEEF_0F1E2D3C);
        chk("c_dout_past_63", extc, 0);
        clr(); run_frame(32, 32);
        chk("c_fe_sat", nfec, 1);
        chk("c_rv_sat", nrvc, 0);
        clr(); run_frame(32, 32);
        chk("c_rv_after_sat", nrvc, 1);
        chk("c_rx_after_sat", rxc, 64'h0F1E2D3C_DEADBEEF);
        enc = 1'b0;

        // Reset mid-frame with lrclk held at FS level
        ena = 1'b1;
        clr(); run_frame(10, 0);
        chk("r_locked_before", lka, 1);
        reset = 1'b1;
        @(posedge bclk); #1;
        chk("r_locked", lka, 0);
        chk("r_rx_valid", rva, 0);
        chk("r_frame_err", fea, 0);
        chk("r_rx_data", rxa, 0);
        @(negedge bclk); #1;
        chk("r_dout", douta, 0);
        reset = 1'b0;
        clr(); run_frame(6, 0);
        chk("r_no_fs_at_level", lka, 0);
        chk("r_no_rv", nrva, 0);
        run_frame(0, 2);
        run_frame(2, 0);
        chk("r_relock", lka, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
